// File: rtl/pid_mimo_2x2_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module : pid_mimo_2x2_if                                                 |
// | Brief  : System-bus port bundle for the 2x2 MIMO PID controller.         |
// | Rev    : 1.0  initial release                                            |
// +--------------------------------------------------------------------------+
interface pid_mimo_2x2_if;
   logic [31:0] sys_addr;
   logic [31:0] sys_wdata;
   logic        sys_wen;
   logic        sys_ren;
   logic [31:0] sys_rdata;
   logic        sys_err;
   logic        sys_ack;

   modport master (
      output sys_addr, sys_wdata, sys_wen, sys_ren,
      input  sys_rdata, sys_err, sys_ack
   );

   modport slave (
      input  sys_addr, sys_wdata, sys_wen, sys_ren,
      output sys_rdata, sys_err, sys_ack
   );
endinterface
`default_nettype wire

// File: rtl/pid_mimo_2x2.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module : pid_mimo_2x2                                                    |
// | Brief  : 2x2 MIMO PID controller, four pipelined sections, bus-tuned.    |
// | Rev    : 1.0  initial release                                            |
// +--------------------------------------------------------------------------+
module pid_mimo_2x2 #(
   parameter int PSR = 12,
   parameter int ISR = 18,
   parameter int DSR = 10
)(
   input  logic                clk_i,
   input  logic                rstn_i,
   input  logic signed [13:0]  dat_a_i,
   input  logic signed [13:0]  dat_b_i,
   output logic signed [13:0]  dat_a_o,
   output logic signed [13:0]  dat_b_o,
   pid_mimo_2x2_if.slave       sys
);

   localparam int c_PROD_W = 29;
   localparam int c_P_W    = c_PROD_W - PSR;
   localparam int c_D_W    = c_PROD_W - DSR;

   function automatic logic signed [13:0] sat14(input logic signed [31:0] v);
      if (v > 32'sd8191)
         return 14'h1FFF;
      else if (v < -32'sd8192)
         return 14'h2000;
      else
         return v[13:0];
   endfunction

   // Coefficient file: index {section, field}, field 0..3 = sp, kp, ki, kd
   logic        [3:0]  r_cfg;
   logic signed [13:0] r_coef [16];
   logic        [31:0] r_rdata;
   logic               r_ack;

   logic [19:0] w_addr;
   logic        w_cfg_hit;
   logic        w_coef_hit;
   logic [1:0]  w_sec_idx;
   logic [3:0]  w_coef_idx;
   logic [31:0] w_rdata;
   logic        w_unused_bus;

   assign w_addr       = sys.sys_addr[19:0];
   assign w_cfg_hit    = (w_addr == 20'h0);
   assign w_coef_hit   = (w_addr[19:8] == 12'h0) && (w_addr[1:0] == 2'b00) &&
                         (w_addr[7:4] >= 4'd1) && (w_addr[7:4] <= 4'd4);
   assign w_sec_idx    = w_addr[5:4] - 2'd1;
   assign w_coef_idx   = {w_sec_idx, w_addr[3:2]};
   assign w_unused_bus = ^{sys.sys_addr[31:20], sys.sys_wdata[31:14]};

   always_comb begin
      w_rdata = '0;
      if (w_cfg_hit)
         w_rdata = {28'h0, r_cfg};
      else if (w_coef_hit)
         w_rdata = {{18{r_coef[w_coef_idx][13]}}, r_coef[w_coef_idx]};
   end

   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         r_cfg   <= '0;
         r_rdata <= '0;
         r_ack   <= 1'b0;
         for (int k = 0; k < 16; k++)
            r_coef[k] <= '0;
      end else begin
         r_ack <= sys.sys_wen | sys.sys_ren;
         if (sys.sys_ren)
            r_rdata <= w_rdata;
         if (sys.sys_wen) begin
            if (w_cfg_hit)
               r_cfg <= sys.sys_wdata[3:0];
            else if (w_coef_hit)
               r_coef[w_coef_idx] <= sys.sys_wdata[13:0];
         end
      end
   end

   assign sys.sys_rdata = r_rdata;
   assign sys.sys_ack   = r_ack;
   assign sys.sys_err   = 1'b0;

   logic signed [13:0] w_sec [4];

   // Sections 0..3 = PID11, PID12, PID21, PID22; even sections read input A
   for (genvar s = 0; s < 4; s++) begin : g_sec
      logic signed [13:0]        w_in;
      logic signed [14:0]        r_err;
      logic signed [c_P_W-1:0]   r_p;
      logic signed [c_D_W-1:0]   r_d_cur;
      logic signed [c_D_W-1:0]   r_d_prev;
      logic signed [31:0]        r_int;
      logic signed [13:0]        r_sec;
      logic signed [28:0]        w_err_x, w_kp_x, w_ki_x, w_kd_x;
      logic signed [28:0]        w_p_prod, w_i_prod, w_d_prod;
      logic        [32:0]        w_int_sum;
      logic signed [31:0]        w_int_next;
      logic signed [31:0]        w_i_term;
      logic signed [31:0]        w_sec_sum;
      logic                      w_unused_lsb;

      assign w_in     = (s % 2 == 0) ? dat_a_i : dat_b_i;
      assign w_err_x  = {{14{r_err[14]}}, r_err};
      assign w_kp_x   = {{15{r_coef[4*s+1][13]}}, r_coef[4*s+1]};
      assign w_ki_x   = {{15{r_coef[4*s+2][13]}}, r_coef[4*s+2]};
      assign w_kd_x   = {{15{r_coef[4*s+3][13]}}, r_coef[4*s+3]};
      assign w_p_prod = w_err_x * w_kp_x;
      assign w_i_prod = w_err_x * w_ki_x;
      assign w_d_prod = w_err_x * w_kd_x;
      assign w_unused_lsb = ^{w_p_prod[PSR-1:0], w_d_prod[DSR-1:0]};

      // One guard bit catches overflow; clamp instead of wrapping
      assign w_int_sum  = {r_int[31], r_int} + {{4{w_i_prod[28]}}, w_i_prod};
      assign w_int_next = (w_int_sum[32] != w_int_sum[31]) ?
                          (w_int_sum[32] ? 32'sh8000_0000 : 32'sh7FFF_FFFF) :
                          w_int_sum[31:0];
      assign w_i_term   = r_int >>> ISR;
      assign w_sec_sum  = {{(32-c_P_W){r_p[c_P_W-1]}}, r_p} + w_i_term +
                          {{(32-c_D_W){r_d_cur[c_D_W-1]}}, r_d_cur} -
                          {{(32-c_D_W){r_d_prev[c_D_W-1]}}, r_d_prev};

      always_ff @(posedge clk_i or negedge rstn_i) begin
         if (!rstn_i) begin
            r_err    <= '0;
            r_p      <= '0;
            r_d_cur  <= '0;
            r_d_prev <= '0;
            r_int    <= '0;
            r_sec    <= '0;
         end else begin
            r_err    <= {r_coef[4*s][13], r_coef[4*s]} - {w_in[13], w_in};
            r_p      <= w_p_prod[c_PROD_W-1:PSR];
            r_d_cur  <= w_d_prod[c_PROD_W-1:DSR];
            r_d_prev <= r_d_cur;
            r_int    <= r_cfg[s] ? 32'sd0 : w_int_next;
            r_sec    <= sat14(w_sec_sum);
         end
      end

      assign w_sec[s] = r_sec;
   end

   logic signed [31:0] w_sum_a;
   logic signed [31:0] w_sum_b;

   assign w_sum_a = {{18{w_sec[0][13]}}, w_sec[0]} + {{18{w_sec[1][13]}}, w_sec[1]};
   assign w_sum_b = {{18{w_sec[2][13]}}, w_sec[2]} + {{18{w_sec[3][13]}}, w_sec[3]};

   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         dat_a_o <= '0;
         dat_b_o <= '0;
      end else begin
         dat_a_o <= sat14(w_sum_a);
         dat_b_o <= sat14(w_sum_b);
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_pid_mimo_2x2.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module : tb_pid_mimo_2x2                                                 |
// | Brief  : Directed, table-driven self-checking bench for pid_mimo_2x2.    |
// | Rev    : 1.0  initial release                                            |
// +--------------------------------------------------------------------------+
module tb_pid_mimo_2x2;

   logic               clk = 1'b0;
   logic               rstn = 1'b0;
   logic signed [13:0] dat_a = '0;
   logic signed [13:0] dat_b = '0;
   logic signed [13:0] out_a;
   logic signed [13:0] out_b;

   pid_mimo_2x2_if bus ();

   pid_mimo_2x2 dut (
      .clk_i   (clk),
      .rstn_i  (rstn),
      .dat_a_i (dat_a),
      .dat_b_i (dat_b),
      .dat_a_o (out_a),
      .dat_b_o (out_b),
      .sys     (bus)
   );

   always #4 clk = ~clk;

   int checks   = 0;
   int failures = 0;

   typedef struct {
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [31:0] exp;
   } bus_vec_t;

   typedef struct {
      int sec; int sp; int kp; int a; int b; int exp_a; int exp_b;
   } p_vec_t;

   bus_vec_t bv [7];
   p_vec_t   pv [8];

   task automatic check(input string name, input logic signed [31:0] act,
                        input logic signed [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
      end
   endtask

   task automatic wait_clks(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
      @(negedge clk);
      bus.sys_addr  = a;
      bus.sys_wdata = d;
      bus.sys_wen   = 1'b1;
      @(negedge clk);
      bus.sys_wen   = 1'b0;
   endtask

   task automatic bus_read(input logic [31:0] a, output logic [31:0] d,
                           output logic ack1, output logic ack2, output logic err);
      @(negedge clk);
      bus.sys_addr = a;
      bus.sys_ren  = 1'b1;
      @(negedge clk);
      bus.sys_ren  = 1'b0;
      d    = bus.sys_rdata;
      ack1 = bus.sys_ack;
      err  = bus.sys_err;
      @(negedge clk);
      ack2 = bus.sys_ack;
   endtask

   task automatic clear_all();
      bus_write(32'h0, 32'h0);
      for (int s = 0; s < 4; s++)
         for (int f = 0; f < 4; f++)
            bus_write(32'h10 + 32'(16 * s) + 32'(4 * f), 32'h0);
   endtask

   initial begin
      #2ms;
      $display("FAIL watchdog time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0]        rd;
      logic               a1, a2, er;
      logic [31:0]        base;
      logic signed [13:0] prev;
      int                 mono_bad;
      int                 hit_at;
      int                 mid_val;
      int                 hist [20];
      int                 sum;
      int                 x_bad, b_bad;
      int                 dexp [6];

      bus.sys_addr  = '0;
      bus.sys_wdata = '0;
      bus.sys_wen   = 1'b0;
      bus.sys_ren   = 1'b0;

      bv[0] = '{32'h14,        32'hFFFF_F448, 32'hFFFF_F448};
      bv[1] = '{32'h2C,        32'h0000_1FFF, 32'h0000_1FFF};
      bv[2] = '{32'h48,        32'h0000_2000, 32'hFFFF_E000};
      bv[3] = '{32'h00,        32'hFFFF_FFF5, 32'h0000_0005};
      bv[4] = '{32'h3C,        32'h1234_5678, 32'h0000_1678};
      bv[5] = '{32'h90,        32'h0000_1234, 32'h0000_0000};
      bv[6] = '{32'h4000_0018, 32'h0000_0123, 32'h0000_0123};

      //         sec  sp     kp     a      b     exp_a  exp_b
      pv[0] = '{0,   100,   4096,  0,     0,    100,   0};
      pv[1] = '{0,   8191,  8191,  -8192, 0,    8191,  0};
      pv[2] = '{0,   -8192, 8191,  8191,  0,    -8192, 0};
      pv[3] = '{1,   0,     2048,  0,     -300, 150,   0};
      pv[4] = '{2,   50,    -4096, 10,    0,    0,     -40};
      pv[5] = '{3,   0,     4096,  0,     7,    0,     -7};
      pv[6] = '{0,   0,     1,     1,     0,    -1,    0};
      pv[7] = '{0,   3,     1,     0,     0,    0,     0};

      // Reset state
      wait_clks(2);
      check("rst_out_a", out_a, 0);
      check("rst_out_b", out_b, 0);
      check("rst_rdata", bus.sys_rdata, 0);
      check("rst_ack", bus.sys_ack, 0);
      rstn = 1'b1;
      bus_read(32'h10, rd, a1, a2, er);
      check("rst_sp11", rd, 0);

      // Register map
      for (int i = 0; i < 7; i++) begin
         bus_write(bv[i].addr, bv[i].wdata);
         bus_read(bv[i].addr, rd, a1, a2, er);
         check($sformatf("bus%0d_rdata", i), rd, bv[i].exp);
         check($sformatf("bus%0d_ack", i), a1, 1);
         check($sformatf("bus%0d_ack_pulse", i), a2, 0);
         check($sformatf("bus%0d_err", i), er, 0);
      end
      clear_all();

      // Proportional path per section
      for (int i = 0; i < 8; i++) begin
         base = 32'h10 + 32'(16 * pv[i].sec);
         bus_write(base, 32'(pv[i].sp));
         bus_write(base + 32'h4, 32'(pv[i].kp));
         dat_a = 14'(pv[i].a);
         dat_b = 14'(pv[i].b);
         wait_clks(6);
         check($sformatf("pvec%0d_a", i), out_a, pv[i].exp_a);
         check($sformatf("pvec%0d_b", i), out_b, pv[i].exp_b);
         bus_write(base, 32'h0);
         bus_write(base + 32'h4, 32'h0);
      end
      dat_a = '0;
      dat_b = '0;

      // Output-stage saturation of PID11 + PID12
      bus_write(32'h14, 32'd4096);
      bus_write(32'h24, 32'd4096);
      bus_write(32'h10, 32'd6000);
      bus_write(32'h20, 32'd5000);
      wait_clks(6);
      check("sum_sat_pos", out_a, 8191);
      bus_write(32'h10, 32'(-6000));
      bus_write(32'h20, 32'(-5000));
      wait_clks(6);
      check("sum_sat_neg", out_a, -8192);
      bus_write(32'h10, 32'd6000);
      wait_clks(6);
      check("sum_mixed", out_a, 1000);
      check("sum_mixed_b", out_b, 0);
      clear_all();

      // Four-clock latency
      bus_write(32'h10, 32'd100);
      bus_write(32'h14, 32'd4096);
      dat_a = 14'sd100;
      wait_clks(6);
      check("lat_pre", out_a, 0);
      dat_a = '0;
      for (int k = 1; k <= 5; k++) begin
         @(negedge clk);
         check($sformatf("lat_k%0d", k), out_a, (k < 4) ? 0 : 100);
      end
      clear_all();

      // Derivative: single pulse on a step
      dexp = '{0, 0, 0, 100, 0, 0};
      bus_write(32'h1C, 32'd1024);
      wait_clks(6);
      check("d_pre", out_a, 0);
      dat_a = -14'sd100;
      for (int k = 0; k < 6; k++) begin
         @(negedge clk);
         check($sformatf("d_k%0d", k + 1), out_a, dexp[k]);
      end
      clear_all();
      dat_a = '0;
      wait_clks(6);

      // Integrator ramp to the rail, hold, reset, resume
      bus_write(32'h10, 32'd1000);
      bus_write(32'h18, 32'd1000);
      prev = '0;
      mono_bad = 0;
      hit_at = -1;
      mid_val = -1;
      for (int i = 1; i <= 3000; i++) begin
         @(negedge clk);
         if (out_a < prev) mono_bad++;
         prev = out_a;
         if (i == 100) mid_val = int'(out_a);
         if (out_a == 14'sd8191) begin
            hit_at = i;
            break;
         end
      end
      check("int_mid_value", mid_val, 373);
      check("int_monotonic", mono_bad, 0);
      check("int_rail_cycle", hit_at, 2150);
      wait_clks(50);
      check("int_stick", out_a, 8191);
      bus_write(32'h0, 32'h1);
      wait_clks(3);
      check("irst_3clk", out_a, 0);
      wait_clks(10);
      check("irst_hold", out_a, 0);
      bus_write(32'h0, 32'h0);
      wait_clks(3);
      check("irst_resume1", out_a, 3);
      wait_clks(1);
      check("irst_resume2", out_a, 7);
      bus_write(32'h0, 32'h1);
      clear_all();
      wait_clks(6);

      // Closed loop against a 20-tap moving-average plant
      bus_write(32'h10, 32'd7000);
      bus_write(32'h14, 32'(-3000));
      bus_write(32'h18, 32'd1000);
      bus_write(32'h1C, 32'd1000);
      bus_write(32'h00, 32'hE);
      for (int k = 0; k < 20; k++) hist[k] = 0;
      x_bad = 0;
      b_bad = 0;
      for (int n = 0; n < 1500; n++) begin
         @(negedge clk);
         if ($isunknown(out_a) || $isunknown(out_b)) x_bad++;
         if (out_b != 14'sd0) b_bad++;
         hist[n % 20] = int'(out_a);
         sum = 0;
         for (int k = 0; k < 20; k++) sum += hist[k];
         dat_a = 14'(sum / 20);
      end
      check("cl_no_x", x_bad, 0);
      check("cl_b_zero", b_bad, 0);

      // Asynchronous reset between clock edges
      @(negedge clk);
      #1;
      rstn = 1'b0;
      #1;
      check("arst_out_a", out_a, 0);
      check("arst_out_b", out_b, 0);
      check("arst_ack", bus.sys_ack, 0);
      @(negedge clk);
      rstn = 1'b1;
      bus_read(32'h10, rd, a1, a2, er);
      check("arst_sp11", rd, 0);
      bus_read(32'h00, rd, a1, a2, er);
      check("arst_cfg", rd, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
`default_nettype wire
